mmio_ctrl: RTL and testbench

Memory-mapped I/O controller for the Riscv151 pipeline. It sits beside the data memory on the EX-stage load/store path, decodes the I/O address window, and sequences byte traffic to and from the UART transmitter and receiver. It also keeps the cycle and retired-instruction performance counters. Load data is registered so it arrives in WB alongside the synchronous dmem read data.

---
 rtl/mmio_ctrl_if.sv | 13 +
 rtl/mmio_ctrl.sv | 113 +++++++++++
 tb/tb_mmio_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_ctrl_if.sv
// Load/store bus between the EX/WB stages and the MMIO controller.
interface mmio_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        re;
  logic        we;
  logic        hit;
  logic        hit_q;
  logic [31:0] rdata;

  modport master (output addr, wdata, re, we, input hit, hit_q, rdata);
  modport slave  (input addr, wdata, re, we, output hit, hit_q, rdata);
endinterface

// File: rtl/mmio_ctrl.sv
// MMIO controller: I/O window decode, UART RX/TX byte holding registers,
// cycle and retired-instruction counters. Load data is registered for WB.
module mmio_ctrl #(
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  mmio_ctrl_if.slave        bus,
  input  logic              inst_retire,
  input  logic [7:0]        uart_rx_data_out,
  input  logic              uart_rx_data_out_valid,
  output logic              uart_rx_data_out_ready,
  output logic [7:0]        uart_tx_data_in,
  output logic              uart_tx_data_in_valid,
  input  logic              uart_tx_data_in_ready
);
  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYC    = 8'h10;
  localparam logic [7:0] OFF_INST   = 8'h14;
  localparam logic [7:0] OFF_CLR    = 8'h18;

  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        tx_full_q, tx_full_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q_q, hit_q_d;

  logic       rd, wr;
  logic [7:0] off;

  assign bus.hit = (bus.addr[31:8] == MMIO_BASE[31:8]);
  assign rd      = bus.re & bus.hit;
  assign wr      = bus.we & bus.hit;
  assign off     = bus.addr[7:0];

  assign uart_rx_data_out_ready = ~rx_full_q;
  assign uart_tx_data_in_valid  = tx_full_q;
  assign uart_tx_data_in        = tx_byte_q;
  assign bus.rdata              = rdata_q;
  assign bus.hit_q              = hit_q_q;

  // Next-state: read mux uses pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rx_full_d   = rx_full_q;
    rx_byte_d   = rx_byte_q;
    tx_full_d   = tx_full_q;
    tx_byte_d   = tx_byte_q;
    cycle_cnt_d = cycle_cnt_q + 32'd1;
    inst_cnt_d  = inst_cnt_q + {31'd0, inst_retire};
    rdata_d     = rdata_q;
    hit_q_d     = rd;

    if (rd) begin
      unique case (off)
        OFF_STATUS: rdata_d = {30'd0, rx_full_q, ~tx_full_q};
        OFF_RX:     rdata_d = {24'd0, rx_byte_q};
        OFF_CYC:    rdata_d = cycle_cnt_q;
        OFF_INST:   rdata_d = inst_cnt_q;
        default:    rdata_d = 32'd0;
      endcase
    end

    // Accept and consume are mutually exclusive: ready is ~rx_full.
    if (uart_rx_data_out_valid && !rx_full_q) begin
      rx_byte_d = uart_rx_data_out;
      rx_full_d = 1'b1;
    end else if (rd && off == OFF_RX) begin
      rx_full_d = 1'b0;
    end

    // Drain and load are exclusive: a store while full is dropped.
    if (tx_full_q && uart_tx_data_in_ready) begin
      tx_full_d = 1'b0;
    end else if (wr && off == OFF_TX && !tx_full_q) begin
      tx_byte_d = bus.wdata[7:0];
      tx_full_d = 1'b1;
    end

    // Counter clear overrides the increment.
    if (wr && off == OFF_CLR) begin
      cycle_cnt_d = 32'd0;
      inst_cnt_d  = 32'd0;
    end
  end

  // State registers, asynchronous reset discards held bytes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_full_q   <= 1'b0;
      rx_byte_q   <= 8'd0;
      tx_full_q   <= 1'b0;
      tx_byte_q   <= 8'd0;
      cycle_cnt_q <= 32'd0;
      inst_cnt_q  <= 32'd0;
      rdata_q     <= 32'd0;
      hit_q_q     <= 1'b0;
    end else begin
      rx_full_q   <= rx_full_d;
      rx_byte_q   <= rx_byte_d;
      tx_full_q   <= tx_full_d;
      tx_byte_q   <= tx_byte_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
      rdata_q     <= rdata_d;
      hit_q_q     <= hit_q_d;
    end
  end
endmodule

// File: tb/tb_mmio_ctrl.sv
// Bench for mmio_ctrl: directed scenarios plus random traffic, all checked
// against a transaction-level model (TX byte queue, RX slot, counters).
module tb_mmio_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inst_retire = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;

  mmio_ctrl_if bus();

  mmio_ctrl dut (
    .clk                    (clk),
    .rst                    (rst),
    .bus                    (bus),
    .inst_retire            (inst_retire),
    .uart_rx_data_out       (rx_data),
    .uart_rx_data_out_valid (rx_valid),
    .uart_rx_data_out_ready (rx_ready),
    .uart_tx_data_in        (tx_data),
    .uart_tx_data_in_valid  (tx_valid),
    .uart_tx_data_in_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] BASE = 32'h8000_0000;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [7:0]  tx_q[$];
  logic        m_rx_full = 1'b0;
  logic [7:0]  m_rx_byte = 8'd0;
  logic [31:0] m_cyc = 0, m_inst = 0, m_rdata = 0;
  logic        m_hitq = 1'b0;
  int          tx_sent = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_bus(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    bus.addr = a; bus.wdata = d; bus.re = r; bus.we = w;
  endtask

  task automatic model_reset();
    tx_q.delete();
    m_rx_full = 0; m_rx_byte = 0; m_cyc = 0; m_inst = 0; m_rdata = 0; m_hitq = 0;
  endtask

  // One clock: predict from inputs/model before the edge, then compare after it.
  task automatic step();
    logic       h, rd, wr, was_full;
    logic [7:0] off;
    h  = (bus.addr >= BASE) && (bus.addr < BASE + 32'd256);
    rd = bus.re && h;
    wr = bus.we && h;
    off = bus.addr[7:0];
    chk("hit", {31'd0, bus.hit}, {31'd0, h});
    m_hitq = rd;
    if (rd) begin
      case (off)
        8'h00:   m_rdata = {30'd0, m_rx_full, tx_q.size() == 0};
        8'h04:   m_rdata = {24'd0, m_rx_byte};
        8'h10:   m_rdata = m_cyc;
        8'h14:   m_rdata = m_inst;
        default: m_rdata = 0;
      endcase
    end
    was_full = (tx_q.size() != 0);
    if (was_full && tx_ready) begin
      chk("tx_xfer_byte", {24'd0, tx_data}, {24'd0, tx_q[0]});
      void'(tx_q.pop_front());
      tx_sent++;
    end
    if (wr && off == 8'h08 && !was_full) tx_q.push_back(bus.wdata[7:0]);
    if (rx_valid && !m_rx_full) begin
      m_rx_full = 1; m_rx_byte = rx_data;
    end else if (rd && off == 8'h04) begin
      m_rx_full = 0;
    end
    if (wr && off == 8'h18) begin
      m_cyc = 0; m_inst = 0;
    end else begin
      m_cyc = m_cyc + 1; m_inst = m_inst + inst_retire;
    end
    @(posedge clk); #1;
    chk("rdata", bus.rdata, m_rdata);
    chk("hit_q", {31'd0, bus.hit_q}, {31'd0, m_hitq});
    chk("rx_ready", {31'd0, rx_ready}, {31'd0, !m_rx_full});
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, tx_q.size() != 0});
    if (tx_q.size() != 0) chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_q[0]});
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic r, input logic w);
    @(negedge clk);
    set_bus(a, d, r, w);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    set_bus(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rst_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_hitq", {31'd0, bus.hit_q}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Status after reset
    cyc(BASE, 0, 1, 0);
    chk("status_rst", bus.rdata, 32'h1);

    // TX with a stall, second store dropped
    tx_ready = 1'b0;
    cyc(BASE + 8, 32'h41, 0, 1);
    idle(2);
    cyc(BASE, 0, 1, 0);
    chk("status_txfull", bus.rdata, 32'h0);
    cyc(BASE + 8, 32'h42, 0, 1);
    chk("tx_held", {24'd0, tx_data}, 32'h41);
    @(negedge clk); tx_ready = 1'b1; set_bus(0, 0, 0, 0); step();
    chk("tx_sent_once", tx_sent, 1);
    chk("tx_done_valid", {31'd0, tx_valid}, 32'd0);
    cyc(BASE, 0, 1, 0);
    chk("status_txdone", bus.rdata, 32'h1);
    tx_ready = 1'b0;

    // RX consume
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'h5A; set_bus(0, 0, 0, 0); step();
    @(negedge clk); rx_valid = 1'b0; set_bus(BASE, 0, 1, 0); step();
    chk("status_rxfull", bus.rdata, 32'h3);
    chk("rx_ready_low", {31'd0, rx_ready}, 32'd0);
    cyc(BASE + 4, 0, 1, 0);
    chk("rx_byte", bus.rdata, 32'h5A);
    cyc(BASE, 0, 1, 0);
    chk("status_rxempty", bus.rdata, 32'h1);
    chk("rx_ready_back", {31'd0, rx_ready}, 32'd1);
    cyc(BASE + 4, 0, 1, 0);
    chk("rx_stale", bus.rdata, 32'h5A);

    // Counters: clear, 100 cycles with exactly 37 retires
    cyc(BASE + 32'h18, 0, 0, 1);
    begin
      int pulses = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        set_bus(0, 0, 0, 0);
        inst_retire = (pulses < 37) && ((i % 3 == 0) || (100 - i <= 37 - pulses));
        if (inst_retire) pulses++;
        step();
      end
    end
    @(negedge clk); inst_retire = 1'b0; set_bus(BASE + 32'h10, 0, 1, 0); step();
    chk("cycle_100", bus.rdata, 32'd100);
    cyc(BASE + 32'h14, 0, 1, 0);
    chk("inst_37", bus.rdata, 32'd37);
    cyc(BASE + 32'h18, 0, 0, 1);
    cyc(BASE + 32'h10, 0, 1, 0);
    chk("cycle_cleared", {31'd0, bus.rdata <= 32'd2}, 32'd1);

    // Clear wins over increment with retire high
    @(negedge clk); inst_retire = 1'b1; set_bus(BASE + 32'h18, 0, 1, 1); step();
    @(negedge clk); inst_retire = 1'b0; set_bus(BASE + 32'h14, 0, 1, 0); step();
    chk("clear_wins", bus.rdata, 32'd0);

    // Wrap
    @(negedge clk);
    force dut.cycle_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cycle_cnt_q;
    m_cyc = 32'hFFFF_FFFF;
    set_bus(BASE + 32'h10, 0, 1, 0);
    step();
    chk("cycle_max", bus.rdata, 32'hFFFF_FFFF);
    cyc(BASE + 32'h10, 0, 1, 0);
    chk("cycle_wrap", bus.rdata, 32'd0);

    // Unmapped offset and out-of-window access
    cyc(BASE + 32'h0C, 0, 1, 0);
    chk("off_0c", bus.rdata, 32'd0);
    cyc(32'h1000_0000, 32'h55, 1, 1);
    chk("miss_hitq", {31'd0, bus.hit_q}, 32'd0);
    chk("miss_hit", {31'd0, bus.hit}, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int sel;
      @(negedge clk);
      sel = $urandom_range(0, 7);
      case (sel)
        0: a = BASE;        1: a = BASE + 4;    2: a = BASE + 8;
        3: a = BASE + 8'h0C; 4: a = BASE + 8'h10; 5: a = BASE + 8'h14;
        6: a = ($urandom_range(0, 9) == 0) ? BASE + 8'h18 : BASE + 4;
        default: a = $urandom;
      endcase
      set_bus(a, $urandom, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      rx_valid    = $urandom_range(0, 2) == 0;
      rx_data     = 8'($urandom);
      tx_ready    = $urandom_range(0, 2) == 0;
      inst_retire = $urandom_range(0, 1) == 1;
      step();
    end

    // Asynchronous reset with both holding registers full
    @(negedge clk);
    tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'hC3; inst_retire = 1'b0;
    set_bus(BASE + 8, 32'h77, 0, 1);
    step();
    @(negedge clk); rx_valid = 1'b0; set_bus(0, 0, 0, 0); step();
    chk("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
    chk("pre_rst_ready", {31'd0, rx_ready}, 32'd0);
    @(negedge clk); #2 rst = 1'b1; #1;
    model_reset();
    chk("arst_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_ready", {31'd0, rx_ready}, 32'd1);
    chk("arst_rdata", bus.rdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    cyc(BASE + 4, 0, 1, 0);
    chk("arst_rxbyte", bus.rdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
